// File: rtl/countdown_pkg.sv
// Countdown timer shared types and limits.
// State encoding, counter maxima and preset clamping.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_e;

  localparam int unsigned MS_MAX  = 999;
  localparam int unsigned SEC_MAX = 59;

  function automatic logic [5:0] clamp_sec(
    input logic [5:0] s
  );
    return (s > 6'(SEC_MAX)) ? 6'(SEC_MAX) : s;
  endfunction

  function automatic logic [9:0] clamp_ms(
    input logic [9:0] m
  );
    return (m > 10'(MS_MAX)) ? 10'(MS_MAX) : m;
  endfunction

endpackage

// File: rtl/countdown_timer_fsm_if.sv
// Countdown timer control/status bundle.
// master drives controls and presets; slave is the timer.
interface countdown_timer_fsm_if;

  logic       start_stop;
  logic       load;
  logic       clear;
  logic [5:0] preset_seconds;
  logic [9:0] preset_ms;
  logic [5:0] seconds;
  logic [9:0] milliseconds;
  logic       status_led;
  logic       done;
  logic       alarm_led;

  modport master (
    output start_stop,
    output load,
    output clear,
    output preset_seconds,
    output preset_ms,
    input  seconds,
    input  milliseconds,
    input  status_led,
    input  done,
    input  alarm_led
  );

  modport slave (
    input  start_stop,
    input  load,
    input  clear,
    input  preset_seconds,
    input  preset_ms,
    output seconds,
    output milliseconds,
    output status_led,
    output done,
    output alarm_led
  );

endinterface

// File: rtl/countdown_timer_fsm_rise_detect.sv
// Rising-edge detector for the start_stop level input.
// One register; the edge is combinational in the same cycle.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  // remember last cycle's level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign edge_o = sig_i & ~sig_q;

endmodule

// File: rtl/countdown_timer_fsm.sv
// Seconds/milliseconds countdown timer with pause and alarm.
// Priority each cycle: clear, load, start_stop edge, countdown.
module countdown_timer_fsm
  import countdown_pkg::*;
#(
  parameter int unsigned ALARM_HALF = 250
) (
  input logic                  clk,
  input logic                  reset,
  countdown_timer_fsm_if.slave bus
);

  localparam int BW = $clog2(ALARM_HALF + 1);

  state_e          state_q, state_d;
  logic [5:0]      sec_q, sec_d;
  logic [9:0]      ms_q, ms_d;
  logic            done_q, done_d;
  logic            alarm_q, alarm_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            rise;
  logic            nonzero;
  logic            last_ms;

  rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (bus.start_stop),
    .edge_o (rise)
  );

  assign nonzero = (sec_q != 6'd0) || (ms_q != 10'd0);
  assign last_ms = (sec_q == 6'd0) && (ms_q == 10'd1);

  // state, counters, done pulse and blink registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q   <= '0;
      ms_q    <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      blink_q <= blink_d;
    end
  end

  // next state with clear > load > edge > countdown
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    done_d  = 1'b0;
    alarm_d = alarm_q;
    blink_d = blink_q;
    if (bus.clear) begin
      state_d = IDLE;
      sec_d   = '0;
      ms_d    = '0;
      alarm_d = 1'b0;
      blink_d = '0;
    end else if (bus.load && state_q != RUNNING) begin
      state_d = IDLE;
      sec_d   = clamp_sec(bus.preset_seconds);
      ms_d    = clamp_ms(bus.preset_ms);
      alarm_d = 1'b0;
      blink_d = '0;
    end else if (rise) begin
      unique case (state_q)
        IDLE: begin
          if (nonzero) state_d = RUNNING;
        end
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        EXPIRED: begin
          state_d = IDLE;
          alarm_d = 1'b0;
          blink_d = '0;
        end
      endcase
    end else begin
      unique case (state_q)
        RUNNING: begin
          if (ms_q != 10'd0) begin
            ms_d = ms_q - 10'd1;
          end else if (sec_q != 6'd0) begin
            ms_d  = 10'(MS_MAX);
            sec_d = sec_q - 6'd1;
          end
          if (last_ms) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
            alarm_d = 1'b1;
            blink_d = '0;
          end
        end
        EXPIRED: begin
          if (blink_q == BW'(ALARM_HALF - 1)) begin
            blink_d = '0;
            alarm_d = ~alarm_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.seconds      = sec_q;
  assign bus.milliseconds = ms_q;
  assign bus.status_led   = (state_q == RUNNING);
  assign bus.done         = done_q;
  assign bus.alarm_led    = alarm_q;

endmodule
